// File: rtl/seg_scan_mux_if.sv
// Display-side bundle for seg_scan_mux: the multi-digit value and mode going in,
// and the decoder and digit-enable drive coming out.
interface seg_scan_mux_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] value;
    logic                hex_mode;
    logic [3:0]          hex;
    logic                show_a2f;
    logic [DIGITS-1:0]   digit_en;
    logic                frame_start;

    modport master (output value, hex_mode, input hex, show_a2f, digit_en, frame_start);
    modport slave  (input value, hex_mode, output hex, show_a2f, digit_en, frame_start);
endinterface

// File: rtl/seg_scan_mux.sv
// Time-multiplexed 7-segment scanner with a per-frame shadow of value and mode.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZ_BLANK_EN.
module seg_scan_mux #(
    parameter  int DIGITS   = 4,
    parameter  int TICK_DIV = 50000,
    localparam int DIV_W    = $clog2(TICK_DIV),
    localparam int IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    seg_scan_mux_if.slave bus
);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [DIV_W-1:0]       div_q, div_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DIGITS-1:0][3:0] shadow_q, shadow_d;
    logic                   mode_q, mode_d;
    logic [DIGITS-1:0]      lit;
    logic                   load;

    assign load = (div_q == '0) && (idx_q == '0);

    always_comb begin
        div_d    = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        mode_d   = mode_q;
        if (div_q == DIV_LAST)
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        if (load) begin
            shadow_d = bus.value;
            mode_d   = bus.hex_mode;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q    <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            mode_q   <= 1'b0;
        end else begin
            div_q    <= div_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            mode_q   <= mode_d;
        end
    end

`ifdef SEG_SCAN_LZ_BLANK_EN
    // A digit stays lit only if it or some more significant nibble is non-zero.
    always_comb begin
        logic acc;
        acc = 1'b0;
        lit = '1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            acc    = acc | (|shadow_q[k]);
            lit[k] = acc;
        end
    end
`else
    assign lit = '1;
`endif

    // Moore decode only; frame_start is held low while reset is asserted.
    always_comb begin
        bus.hex         = 4'h0;
        bus.digit_en    = '0;
        bus.show_a2f    = mode_q;
        bus.frame_start = load & rst_n;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                bus.hex         = shadow_q[k];
                bus.digit_en[k] = (div_q != '0) && lit[k];
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux: directed scenarios plus randomized scanning
// compared against a cycle-count based reference model.
module tb_seg_scan_mux;
    localparam int D = 4;
    localparam int T = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst1_n = 1'b0;
    always #5 clk = ~clk;

    seg_scan_mux_if #(.DIGITS(D)) bus ();
    seg_scan_mux_if #(.DIGITS(1)) bus1 ();

    seg_scan_mux #(.DIGITS(D), .TICK_DIV(T)) dut  (.clk(clk), .rst_n(rst_n),  .bus(bus));
    seg_scan_mux #(.DIGITS(1), .TICK_DIV(2)) dut1 (.clk(clk), .rst_n(rst1_n), .bus(bus1));

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc;
    logic [15:0] m_shadow;
    logic        m_mode;

    // Reference: position in the scan follows directly from cycles since reset release.
    function automatic logic [3:0] e_hex(int c);
        int s = (c / T) % D;
        return 4'(m_shadow >> (4 * s));
    endfunction

    function automatic logic [D-1:0] e_en(int c);
        int s = (c / T) % D;
        bit on = 1'b1;
        if (c % T == 0) return '0;
`ifdef SEG_SCAN_LZ_BLANK_EN
        on = (s == 0) || ((m_shadow >> (4 * s)) != 16'h0);
`endif
        return on ? D'(1 << s) : '0;
    endfunction

    function automatic logic e_fs(int c);
        return (c % (D * T)) == 0;
    endfunction

    task automatic reset_dut(input logic [15:0] v, input logic m);
        @(negedge clk);
        rst_n = 1'b0;
        bus.value = v;
        bus.hex_mode = m;
        repeat (2) @(negedge clk);
        m_shadow = '0;
        m_mode = 1'b0;
        cyc = 0;
        rst_n = 1'b1;
    endtask

    task automatic model_update();
        if (e_fs(cyc)) begin
            m_shadow = bus.value;
            m_mode = bus.hex_mode;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        bus.value = 16'hFFFF;
        bus.hex_mode = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (bus.hex !== 4'h0) begin n_bad++; $display("FAIL reset_hex got %h want 0", bus.hex); end
        n_cmp++; if (bus.digit_en !== '0) begin n_bad++; $display("FAIL reset_en got %b want 0", bus.digit_en); end
        n_cmp++; if (bus.show_a2f !== 1'b0) begin n_bad++; $display("FAIL reset_a2f got %b want 0", bus.show_a2f); end
        n_cmp++; if (bus.frame_start !== 1'b0) begin n_bad++; $display("FAIL reset_fs got %b want 0", bus.frame_start); end
    endtask

    task automatic test_first_frame();
        reset_dut(16'h1234, 1'b1);
        while (cyc <= 17) begin
            #1;
            n_cmp++;
            if ({bus.hex, bus.digit_en, bus.frame_start, bus.show_a2f} !== {e_hex(cyc), e_en(cyc), e_fs(cyc), m_mode}) begin
                n_bad++;
                $display("FAIL first_frame c%0d got hex=%h en=%b fs=%b a2f=%b want hex=%h en=%b fs=%b a2f=%b", cyc,
                         bus.hex, bus.digit_en, bus.frame_start, bus.show_a2f, e_hex(cyc), e_en(cyc), e_fs(cyc), m_mode);
            end
            if (cyc == 0) begin
                n_cmp++; if (bus.frame_start !== 1'b1 || bus.digit_en !== 4'b0) begin
                    n_bad++; $display("FAIL first_c0 got fs=%b en=%b want fs=1 en=0000", bus.frame_start, bus.digit_en); end
            end
            if (cyc == 1) begin
                n_cmp++; if (bus.hex !== 4'h4 || bus.digit_en !== 4'b0001) begin
                    n_bad++; $display("FAIL first_c1 got hex=%h en=%b want hex=4 en=0001", bus.hex, bus.digit_en); end
            end
            if (cyc == 4) begin
                n_cmp++; if (bus.digit_en !== 4'b0) begin
                    n_bad++; $display("FAIL first_gap got en=%b want 0000", bus.digit_en); end
            end
            if (cyc == 6) begin
                n_cmp++; if (bus.hex !== 4'h3 || bus.digit_en !== 4'b0010) begin
                    n_bad++; $display("FAIL first_c6 got hex=%h en=%b want hex=3 en=0010", bus.hex, bus.digit_en); end
            end
            if (cyc == 16) begin
                n_cmp++; if (bus.frame_start !== 1'b1) begin
                    n_bad++; $display("FAIL first_c16_fs got %b want 1", bus.frame_start); end
            end
            model_update();
        end
    endtask

    task automatic test_frame_coherence();
        reset_dut(16'h1234, 1'b0);
        while (cyc <= 20) begin
            #1;
            n_cmp++;
            if ({bus.hex, bus.digit_en, bus.frame_start} !== {e_hex(cyc), e_en(cyc), e_fs(cyc)}) begin
                n_bad++;
                $display("FAIL coherence c%0d got hex=%h en=%b fs=%b want hex=%h en=%b fs=%b", cyc,
                         bus.hex, bus.digit_en, bus.frame_start, e_hex(cyc), e_en(cyc), e_fs(cyc));
            end
            if (cyc == 9) begin
                n_cmp++; if (bus.hex !== 4'h2) begin n_bad++; $display("FAIL coh_d2 got %h want 2", bus.hex); end
            end
            if (cyc == 13) begin
                n_cmp++; if (bus.hex !== 4'h1) begin n_bad++; $display("FAIL coh_d3 got %h want 1", bus.hex); end
            end
            if (cyc == 17) begin
                n_cmp++; if (bus.hex !== 4'hD) begin n_bad++; $display("FAIL coh_new got %h want d", bus.hex); end
            end
            if (cyc == 6) bus.value = 16'hABCD;
            model_update();
        end
    endtask

    task automatic test_mode_sampling();
        reset_dut(16'h1234, 1'b0);
        while (cyc <= 18) begin
            #1;
            n_cmp++;
            if (bus.show_a2f !== m_mode) begin
                n_bad++; $display("FAIL mode c%0d got %b want %b", cyc, bus.show_a2f, m_mode);
            end
            if (cyc == 12) begin
                n_cmp++; if (bus.show_a2f !== 1'b0) begin n_bad++; $display("FAIL mode_hold got %b want 0", bus.show_a2f); end
            end
            if (cyc == 17) begin
                n_cmp++; if (bus.show_a2f !== 1'b1) begin n_bad++; $display("FAIL mode_new got %b want 1", bus.show_a2f); end
            end
            if (cyc == 8) bus.hex_mode = 1'b1;
            model_update();
        end
    endtask

    task automatic test_async_reset();
        reset_dut(16'h5678, 1'b1);
        while (cyc <= 10) begin
            #1;
            n_cmp++;
            if ({bus.hex, bus.digit_en} !== {e_hex(cyc), e_en(cyc)}) begin
                n_bad++; $display("FAIL pre_rst c%0d got hex=%h en=%b want hex=%h en=%b", cyc,
                                  bus.hex, bus.digit_en, e_hex(cyc), e_en(cyc));
            end
            if (cyc == 10) begin
                #2 rst_n = 1'b0;
                #1;
                n_cmp++;
                if (bus.digit_en !== '0 || bus.hex !== 4'h0) begin
                    n_bad++; $display("FAIL async_rst got hex=%h en=%b want hex=0 en=0000", bus.hex, bus.digit_en);
                end
            end
            model_update();
        end
        @(negedge clk);
        m_shadow = '0;
        m_mode = 1'b0;
        cyc = 0;
        rst_n = 1'b1;
        while (cyc <= 6) begin
            #1;
            n_cmp++;
            if ({bus.hex, bus.digit_en, bus.frame_start, bus.show_a2f} !== {e_hex(cyc), e_en(cyc), e_fs(cyc), m_mode}) begin
                n_bad++;
                $display("FAIL restart c%0d got hex=%h en=%b fs=%b a2f=%b want hex=%h en=%b fs=%b a2f=%b", cyc,
                         bus.hex, bus.digit_en, bus.frame_start, bus.show_a2f, e_hex(cyc), e_en(cyc), e_fs(cyc), m_mode);
            end
            model_update();
        end
    endtask

    task automatic test_lz_blank(input logic [15:0] v, input int want0, input int want1, input int want2, input int want3);
        int cnt [D];
        int want [D];
        want = '{want0, want1, want2, want3};
        foreach (cnt[k]) cnt[k] = 0;
        reset_dut(v, 1'b0);
        while (cyc < 2 * D * T) begin
            #1;
            if (cyc >= D * T)
                for (int k = 0; k < D; k++) cnt[k] += int'(bus.digit_en[k]);
            n_cmp++;
            if (bus.digit_en !== e_en(cyc) || bus.hex !== e_hex(cyc)) begin
                n_bad++; $display("FAIL lz c%0d v=%h got hex=%h en=%b want hex=%h en=%b", cyc, v,
                                  bus.hex, bus.digit_en, e_hex(cyc), e_en(cyc));
            end
            model_update();
        end
        for (int k = 0; k < D; k++) begin
            n_cmp++;
            if (cnt[k] != want[k]) begin
                n_bad++; $display("FAIL lz_count v=%h digit%0d got %0d lit cycles want %0d", v, k, cnt[k], want[k]);
            end
        end
    endtask

    task automatic test_random();
        reset_dut(16'($urandom), 1'($urandom));
        while (cyc < 400) begin
            #1;
            n_cmp++;
            if ({bus.hex, bus.digit_en, bus.frame_start, bus.show_a2f} !== {e_hex(cyc), e_en(cyc), e_fs(cyc), m_mode}) begin
                n_bad++;
                $display("FAIL random c%0d got hex=%h en=%b fs=%b a2f=%b want hex=%h en=%b fs=%b a2f=%b", cyc,
                         bus.hex, bus.digit_en, bus.frame_start, bus.show_a2f, e_hex(cyc), e_en(cyc), e_fs(cyc), m_mode);
            end
            if ($urandom_range(0, 5) == 0)
                bus.value = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 4)));
            if ($urandom_range(0, 9) == 0)
                bus.hex_mode = ~bus.hex_mode;
            model_update();
        end
    endtask

    task automatic test_digits1();
        logic [3:0] sh;
        logic       md;
        @(negedge clk);
        rst1_n = 1'b0;
        bus1.value = 4'h7;
        bus1.hex_mode = 1'b1;
        @(negedge clk);
        sh = 4'h0;
        md = 1'b0;
        rst1_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            n_cmp++;
            if ({bus1.frame_start, bus1.digit_en, bus1.hex, bus1.show_a2f} !== {(c % 2 == 0), (c % 2 == 1), sh, md}) begin
                n_bad++;
                $display("FAIL digits1 c%0d got fs=%b en=%b hex=%h a2f=%b want fs=%b en=%b hex=%h a2f=%b", c,
                         bus1.frame_start, bus1.digit_en, bus1.hex, bus1.show_a2f, (c % 2 == 0), (c % 2 == 1), sh, md);
            end
            if (c == 3) bus1.value = 4'h9;
            if (c % 2 == 0) begin
                sh = bus1.value;
                md = bus1.hex_mode;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        bus1.value = 4'h0;
        bus1.hex_mode = 1'b0;
        test_reset();
        test_first_frame();
        test_frame_coherence();
        test_mode_sampling();
        test_async_reset();
`ifdef SEG_SCAN_LZ_BLANK_EN
        test_lz_blank(16'h0050, T - 1, T - 1, 0, 0);
        test_lz_blank(16'h0000, T - 1, 0, 0, 0);
`else
        test_lz_blank(16'h0050, T - 1, T - 1, T - 1, T - 1);
        test_lz_blank(16'h0000, T - 1, T - 1, T - 1, T - 1);
`endif
        test_random();
        test_digits1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
